// File: rtl/riscv_mon_pkg.sv
// Shared types for the run monitor: FSM states, fail_code encodings and
// the hit index width helper.
package riscv_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } mon_state_e;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_WATCH   = 2'd1,
      FC_TIMEOUT = 2'd2,
      FC_HANG    = 2'd3
   } fail_code_e;

   // Width of a channel index; a single channel still needs one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/riscv_watch_match.sv
// Combinational end-of-run watch comparators with lowest-index priority.
module riscv_watch_match
   import riscv_mon_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int NUM_WATCH = 2,
   parameter int IDX_W     = idx_width(NUM_WATCH)
) (
   input  logic [XLEN-1:0]           i_addr,
   input  logic [4:0]                i_rd,
   input  logic                      i_we,
   input  logic [NUM_WATCH-1:0]      i_cfg_en,
   input  logic [NUM_WATCH*XLEN-1:0] i_cfg_addr,
   input  logic [NUM_WATCH*5-1:0]    i_cfg_rd,
   input  logic [NUM_WATCH-1:0]      i_cfg_pass,
   input  logic [NUM_WATCH-1:0]      i_cfg_need_we,
   output logic                      o_hit,
   output logic [IDX_W-1:0]          o_hit_idx,
   output logic                      o_hit_pass
);

   logic [NUM_WATCH-1:0] w_match;

   for (genvar g = 0; g < NUM_WATCH; g++) begin : g_ch
      assign w_match[g] = i_cfg_en[g]
                        && (i_addr == i_cfg_addr[g*XLEN +: XLEN])
                        && (i_rd == i_cfg_rd[g*5 +: 5])
                        && (!i_cfg_need_we[g] || i_we);
   end

   // Scan from the top down so the lowest matching channel is the one left standing.
   always_comb begin
      o_hit      = |w_match;
      o_hit_idx  = '0;
      o_hit_pass = 1'b0;
      for (int i = NUM_WATCH - 1; i >= 0; i--) begin
         if (w_match[i]) begin
            o_hit_idx  = IDX_W'(i);
            o_hit_pass = i_cfg_pass[i];
         end
      end
   end

endmodule

// File: rtl/riscv_run_monitor.sv
// Run monitor: watches a core for an end-of-run write, a pc hang or a
// cycle timeout and reports a latched pass/fail verdict.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start after reset
// ST_RUN   | counting cycles, checking watches, hang and timeout
// ST_DRAIN | watch result latched, letting the pipeline settle
// ST_DONE  | verdict valid and held; start begins a new run
//
// A watch hit is captured on the edge it is seen and acted on one edge
// later, so the retiring write-back cycle is still counted as a RUN cycle.
// Hang and timeout end the run on the edge they are seen, leaving
// cycle_count at the index of the last RUN cycle.
module riscv_run_monitor
   import riscv_mon_pkg::*;
#(
   parameter  int XLEN         = 32,
   parameter  int NUM_WATCH    = 2,
   parameter  int CNT_W        = 16,
   parameter  int MAX_CYCLES   = 1000,
   parameter  int HANG_LIMIT   = 8,
   parameter  int DRAIN_CYCLES = 2,
   localparam int IDX_W        = idx_width(NUM_WATCH)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [XLEN-1:0]           pc,
   input  logic [XLEN-1:0]           addr,
   input  logic [4:0]                rdId,
   input  logic                      regWrite,
   input  logic [NUM_WATCH-1:0]      cfg_en,
   input  logic [NUM_WATCH*XLEN-1:0] cfg_addr,
   input  logic [NUM_WATCH*5-1:0]    cfg_rd,
   input  logic [NUM_WATCH-1:0]      cfg_pass,
   input  logic [NUM_WATCH-1:0]      cfg_need_we,
   output logic                      done,
   output logic                      pass,
   output logic [1:0]                fail_code,
   output logic [IDX_W-1:0]          hit_idx,
   output logic [CNT_W-1:0]          cycle_count
);

   localparam int               HANG_W     = $clog2(HANG_LIMIT + 1);
   localparam logic [HANG_W-1:0] HANG_TC   = HANG_W'(HANG_LIMIT - 2);
   localparam logic [CNT_W-1:0]  TMO_TC    = CNT_W'(MAX_CYCLES - 1);
   localparam logic [3:0]        DRAIN_LOAD = (DRAIN_CYCLES > 0) ? 4'(DRAIN_CYCLES - 1) : 4'd0;

   mon_state_e        r_state, w_state_nxt;
   logic [CNT_W-1:0]  r_cycle;
   logic [HANG_W-1:0] r_hang;
   logic [XLEN-1:0]   r_prev_pc;
   logic [3:0]        r_drain;
   logic              r_hit_pend;
   logic              r_pass;
   fail_code_e        r_fail_code;
   logic [IDX_W-1:0]  r_hit_idx;

   logic              w_hit, w_hit_pass;
   logic [IDX_W-1:0]  w_hit_idx;
   logic              w_pc_same, w_hang_evt, w_tmo_evt;
   logic              w_clear, w_take_hit, w_end_fail, w_cnt_en, w_drain_load;
   fail_code_e        w_end_code;

   riscv_watch_match #(
      .XLEN      (XLEN),
      .NUM_WATCH (NUM_WATCH),
      .IDX_W     (IDX_W)
   ) u_match (
      .i_addr        (addr),
      .i_rd          (rdId),
      .i_we          (regWrite),
      .i_cfg_en      (cfg_en),
      .i_cfg_addr    (cfg_addr),
      .i_cfg_rd      (cfg_rd),
      .i_cfg_pass    (cfg_pass),
      .i_cfg_need_we (cfg_need_we),
      .o_hit         (w_hit),
      .o_hit_idx     (w_hit_idx),
      .o_hit_pass    (w_hit_pass)
   );

   assign w_pc_same  = (pc == r_prev_pc);
   assign w_hang_evt = w_pc_same && (r_hang == HANG_TC);
   assign w_tmo_evt  = (r_cycle == TMO_TC);

   // Next state and per-edge control strobes; priority is hit > hang > timeout.
   always_comb begin
      w_state_nxt  = r_state;
      w_clear      = 1'b0;
      w_take_hit   = 1'b0;
      w_end_fail   = 1'b0;
      w_end_code   = FC_NONE;
      w_cnt_en     = 1'b0;
      w_drain_load = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               w_state_nxt = ST_RUN;
               w_clear     = 1'b1;
            end
         end
         ST_RUN: begin
            w_cnt_en = 1'b1;
            if (r_hit_pend) begin
               w_drain_load = 1'b1;
               w_state_nxt  = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
            end else if (w_hit) begin
               w_take_hit = 1'b1;
            end else if (w_hang_evt) begin
               w_cnt_en    = 1'b0;
               w_end_fail  = 1'b1;
               w_end_code  = FC_HANG;
               w_state_nxt = ST_DONE;
            end else if (w_tmo_evt) begin
               w_cnt_en    = 1'b0;
               w_end_fail  = 1'b1;
               w_end_code  = FC_TIMEOUT;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DRAIN: begin
            if (r_drain == '0) w_state_nxt = ST_DONE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Counters, previous pc and the latched verdict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle     <= '0;
         r_hang      <= '0;
         r_prev_pc   <= '0;
         r_drain     <= '0;
         r_hit_pend  <= 1'b0;
         r_pass      <= 1'b0;
         r_fail_code <= FC_NONE;
         r_hit_idx   <= '0;
      end else begin
         r_prev_pc <= pc;
         if (w_clear) begin
            r_cycle     <= '0;
            r_hang      <= '0;
            r_drain     <= '0;
            r_hit_pend  <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_code <= FC_NONE;
            r_hit_idx   <= '0;
         end else begin
            if (w_cnt_en && (r_cycle != '1)) r_cycle <= r_cycle + 1'b1;
            if (r_state == ST_RUN) r_hang <= w_pc_same ? r_hang + 1'b1 : '0;
            if (w_take_hit) begin
               r_hit_pend  <= 1'b1;
               r_pass      <= w_hit_pass;
               r_fail_code <= w_hit_pass ? FC_NONE : FC_WATCH;
               r_hit_idx   <= w_hit_idx;
            end
            if (w_drain_load) begin
               r_hit_pend <= 1'b0;
               r_drain    <= DRAIN_LOAD;
            end else if ((r_state == ST_DRAIN) && (r_drain != '0)) begin
               r_drain <= r_drain - 1'b1;
            end
            if (w_end_fail) begin
               r_pass      <= 1'b0;
               r_fail_code <= w_end_code;
            end
         end
      end
   end

   assign done        = (r_state == ST_DONE);
   assign pass        = r_pass;
   assign fail_code   = r_fail_code;
   assign hit_idx     = r_hit_idx;
   assign cycle_count = r_cycle;

endmodule

// File: tb/tb_riscv_run_monitor.sv
// Scoreboard bench for riscv_run_monitor: the driver queues the expected
// verdict when it starts a run, the monitor checks it when done rises.
module tb_riscv_run_monitor;

   localparam logic [31:0] NOADDR = 32'h0000_FFF0;

   typedef struct {
      string       name;
      logic        e_pass;
      logic [1:0]  e_fc;
      logic        e_idx;
      logic [15:0] e_cnt;
      int          e_edge;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] pc, addr;
   logic [4:0]  rdId;
   logic        regWrite;
   logic [1:0]  cfg_en, cfg_pass, cfg_need_we;
   logic [63:0] cfg_addr;
   logic [9:0]  cfg_rd;
   logic        done, pass;
   logic [1:0]  fail_code;
   logic        hit_idx;
   logic [15:0] cycle_count;

   int   checks   = 0;
   int   failures = 0;
   int   edge_cnt = 0;
   exp_t exp_q[$];

   riscv_run_monitor #(
      .XLEN(32), .NUM_WATCH(2), .CNT_W(16),
      .MAX_CYCLES(20), .HANG_LIMIT(8), .DRAIN_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .pc(pc), .addr(addr),
      .rdId(rdId), .regWrite(regWrite), .cfg_en(cfg_en), .cfg_addr(cfg_addr),
      .cfg_rd(cfg_rd), .cfg_pass(cfg_pass), .cfg_need_we(cfg_need_we),
      .done(done), .pass(pass), .fail_code(fail_code), .hit_idx(hit_idx),
      .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: compare the queued verdict on every rising edge of done.
   initial begin
      logic done_q;
      exp_t e;
      done_q = 1'b0;
      forever begin
         @(negedge clk);
         if (done === 1'b1 && !done_q) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done actual=1 expected=0 at edge %0d", edge_cnt);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_pass"}, 32'(pass), 32'(e.e_pass));
               chk({e.name, "_fail_code"}, 32'(fail_code), 32'(e.e_fc));
               chk({e.name, "_hit_idx"}, 32'(hit_idx), 32'(e.e_idx));
               chk({e.name, "_cycle_count"}, 32'(cycle_count), 32'(e.e_cnt));
               chk({e.name, "_done_edge"}, 32'(edge_cnt), 32'(e.e_edge));
            end
         end
         done_q = (done === 1'b1);
      end
   end

   // pc mode: 0 advance by 4, 1 hold, 2 jump to 0x40
   task automatic tick(input logic [31:0] a, input logic [4:0] rd, input logic we, input int mode);
      @(negedge clk);
      start    = 1'b0;
      addr     = a;
      rdId     = rd;
      regWrite = we;
      if (mode == 0)      pc = pc + 32'd4;
      else if (mode == 2) pc = 32'h40;
   endtask

   task automatic begin_run(output int s);
      @(negedge clk);
      start    = 1'b1;
      pc       = pc + 32'd4;
      addr     = NOADDR;
      rdId     = 5'd0;
      regWrite = 1'b0;
      s        = edge_cnt + 1;
   endtask

   task automatic push_exp(input string nm, input logic p, input logic [1:0] fc,
                           input logic idx, input int cnt, input int edge_n);
      exp_t e;
      e.name   = nm;
      e.e_pass = p;
      e.e_fc   = fc;
      e.e_idx  = idx;
      e.e_cnt  = 16'(cnt);
      e.e_edge = edge_n;
      exp_q.push_back(e);
   endtask

   task automatic idle_until_empty(input string nm, input int mode);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(NOADDR, 5'd0, 1'b0, mode);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL %s_no_done actual=pending expected=done", nm);
         exp_q.delete();
      end
   endtask

   // Hit on count c: captured at start_edge+c+1, done visible at start_edge+c+4, count c+2.
   task automatic match_run(input string nm, input int c, input logic [31:0] a, input logic [4:0] rd,
                            input logic p, input logic [1:0] fc, input logic idx);
      int s;
      begin_run(s);
      push_exp(nm, p, fc, idx, c + 2, s + c + 4);
      for (int i = 0; i < c; i++) tick(NOADDR, 5'd0, 1'b0, 0);
      tick(a, rd, 1'b1, 0);
      idle_until_empty(nm, 0);
   endtask

   initial begin
      #100000;
      failures++;
      $display("FAIL watchdog actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      int s;
      reset = 1'b1; start = 1'b0; pc = 32'h1000; addr = NOADDR; rdId = 5'd0; regWrite = 1'b0;
      cfg_en = 2'b00; cfg_addr = '0; cfg_rd = '0; cfg_pass = 2'b00; cfg_need_we = 2'b00;
      repeat (2) @(negedge clk);
      chk("rst_done", 32'(done), 0);
      chk("rst_pass", 32'(pass), 0);
      chk("rst_fail_code", 32'(fail_code), 0);
      chk("rst_hit_idx", 32'(hit_idx), 0);
      chk("rst_cycle_count", 32'(cycle_count), 0);
      reset = 1'b0;
      tick(NOADDR, 5'd0, 1'b0, 0);
      chk("idle_done", 32'(done), 0);

      // single channel, hit at RUN cycle 12
      cfg_en = 2'b01; cfg_addr = {32'h0, 32'h36}; cfg_rd = {5'd0, 5'hA};
      cfg_pass = 2'b01; cfg_need_we = 2'b00;
      match_run("t1_ch0", 12, 32'h36, 5'hA, 1'b1, 2'd0, 1'b0);

      // both channels match: ch0 wins regardless of ch1's pass bit
      cfg_en = 2'b11; cfg_addr = {32'h100, 32'h100}; cfg_rd = {5'd5, 5'd5};
      cfg_pass = 2'b01;
      match_run("t2_both", 3, 32'h100, 5'd5, 1'b1, 2'd0, 1'b0);
      cfg_pass = 2'b10;
      match_run("t3_swap", 3, 32'h100, 5'd5, 1'b0, 2'd1, 1'b0);

      // only ch1 matches, failing channel
      cfg_addr = {32'h100, 32'h104}; cfg_pass = 2'b01;
      match_run("t4_ch1", 6, 32'h100, 5'd5, 1'b0, 2'd1, 1'b1);

      // timeout with a stray start mid-run that must be ignored
      begin_run(s);
      push_exp("t5_tmo", 1'b0, 2'd2, 1'b0, 19, s + 20);
      for (int i = 0; i < 10; i++) tick(NOADDR, 5'd0, 1'b0, 0);
      @(negedge clk); start = 1'b1; pc = pc + 32'd4;
      idle_until_empty("t5_tmo", 0);
      repeat (3) tick(NOADDR, 5'd0, 1'b0, 0);
      chk("t5_frozen_cnt", 32'(cycle_count), 19);
      chk("t5_done_held", 32'(done), 1);

      // hang: pc parked at 0x40 from RUN cycle 5
      cfg_en = 2'b01; cfg_addr = {32'h0, 32'h36}; cfg_rd = {5'd0, 5'hA}; cfg_pass = 2'b01;
      begin_run(s);
      push_exp("t6_hang", 1'b0, 2'd3, 1'b0, 12, s + 13);
      for (int i = 0; i < 5; i++) tick(NOADDR, 5'd0, 1'b0, 0);
      tick(NOADDR, 5'd0, 1'b0, 2);
      idle_until_empty("t6_hang", 1);

      // hang and watch hit on the same cycle: the watch wins
      begin_run(s);
      push_exp("t7_hang_hit", 1'b1, 2'd0, 1'b0, 14, s + 16);
      for (int i = 0; i < 5; i++) tick(NOADDR, 5'd0, 1'b0, 0);
      tick(NOADDR, 5'd0, 1'b0, 2);
      for (int i = 6; i < 12; i++) tick(NOADDR, 5'd0, 1'b0, 1);
      tick(32'h36, 5'hA, 1'b0, 1);
      idle_until_empty("t7_hang_hit", 1);

      // need_we: no hit without regWrite; disabled ch1 must not fire either
      cfg_en = 2'b01; cfg_addr = {32'h80, 32'h80}; cfg_rd = {5'd3, 5'd3};
      cfg_pass = 2'b01; cfg_need_we = 2'b01;
      begin_run(s);
      push_exp("t8_need_we", 1'b1, 2'd0, 1'b0, 7, s + 9);
      for (int i = 0; i < 4; i++) tick(NOADDR, 5'd0, 1'b0, 0);
      tick(32'h80, 5'd3, 1'b0, 0);
      tick(32'h80, 5'd3, 1'b1, 0);
      idle_until_empty("t8_need_we", 0);

      // asynchronous reset in the middle of DRAIN
      cfg_en = 2'b10; cfg_addr = {32'h36, 32'h0}; cfg_rd = {5'hA, 5'd0};
      cfg_pass = 2'b10; cfg_need_we = 2'b00;
      begin_run(s);
      tick(NOADDR, 5'd0, 1'b0, 0);
      tick(NOADDR, 5'd0, 1'b0, 0);
      tick(32'h36, 5'hA, 1'b0, 0);
      tick(NOADDR, 5'd0, 1'b0, 0);
      tick(NOADDR, 5'd0, 1'b0, 0);
      chk("t9_pre_pass", 32'(pass), 1);
      chk("t9_pre_hit_idx", 32'(hit_idx), 1);
      chk("t9_pre_cycle_count", 32'(cycle_count), 4);
      chk("t9_pre_done", 32'(done), 0);
      #1 reset = 1'b1;
      #1;
      chk("t9_rst_done", 32'(done), 0);
      chk("t9_rst_pass", 32'(pass), 0);
      chk("t9_rst_fail_code", 32'(fail_code), 0);
      chk("t9_rst_hit_idx", 32'(hit_idx), 0);
      chk("t9_rst_cycle_count", 32'(cycle_count), 0);

      // start sampled on the first edge after release, rerun from zero
      @(negedge clk);
      reset = 1'b0; start = 1'b1; pc = pc + 32'd4; addr = NOADDR;
      s = edge_cnt + 1;
      push_exp("t10_rerun", 1'b1, 2'd0, 1'b1, 2, s + 4);
      tick(32'h36, 5'hA, 1'b0, 0);
      idle_until_empty("t10_rerun", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/riscv_run_monitor.md
RISCV_RUN_MONITOR -- requirements
Module: riscv_run_monitor

Interface
REQ-001 SHALL have parameter XLEN, 32, address/PC width.
REQ-002 SHALL have parameter NUM_WATCH, 2, number of end-of-run watch channels (1..8).
REQ-003 SHALL have parameter CNT_W, 16, cycle counter width.
REQ-004 SHALL have parameter MAX_CYCLES, 1000, timeout limit in RUN cycles (1..2^CNT_W-1).
REQ-005 SHALL have parameter HANG_LIMIT, 8, consecutive cycles with unchanged pc that count as a hang (>=2).
REQ-006 SHALL have parameter DRAIN_CYCLES, 2, cycles between watch hit and done (0..15).
REQ-007 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-009 SHALL have ports start (in, 1), pc (in, XLEN), addr (in, XLEN), rdId (in, 5) and regWrite (in, 1); the last four are the observed core signals.
REQ-010 SHALL have cfg_en (in, NUM_WATCH), cfg_addr (in, NUM_WATCH*XLEN, channel i at bits [i*XLEN +: XLEN]), cfg_rd (in, NUM_WATCH*5), cfg_pass (in, NUM_WATCH; 1 = hit means pass) and cfg_need_we (in, NUM_WATCH; 1 = match also requires regWrite).
REQ-011 SHALL have outputs done (1), pass (1), fail_code (2: 0 none, 1 watch-fail, 2 timeout, 3 hang), hit_idx (max(1,$clog2(NUM_WATCH))) and cycle_count (CNT_W).

Function
REQ-012 SHALL implement FSM IDLE, RUN, DRAIN, DONE; reset enters IDLE.
REQ-013 IDLE->RUN on start=1; cycle_count, hang counter, drain counter and results clear on that edge.
REQ-014 Channel i matches when cfg_en[i] & addr==cfg_addr[i] & rdId==cfg_rd[i] & (!cfg_need_we[i] | regWrite); match is evaluated only in RUN.
REQ-015 Simultaneous matches: lowest index wins; hit_idx latches it.
REQ-016 In RUN cycle_count increments by 1 per cycle and saturates at all-ones; it freezes outside RUN.
REQ-017 Hang counter increments when pc equals the previous-cycle pc, else resets to 0; reaching HANG_LIMIT-1 with pc still equal is a hang event.
REQ-018 Timeout event when cycle_count == MAX_CYCLES-1 in RUN.
REQ-019 Event precedence within one cycle: watch hit > hang > timeout.
REQ-020 Watch hit: latch pass=cfg_pass[idx], fail_code=cfg_pass[idx]?0:1, go to DRAIN (DRAIN_CYCLES=0: go directly to DONE).
REQ-021 DRAIN counts DRAIN_CYCLES cycles, then DONE; further matches during DRAIN are ignored.
REQ-022 Hang or timeout: latch pass=0, fail_code=3 or 2, go directly to DONE.
REQ-023 done=1 exactly while in DONE (registered, first asserted the cycle after the transition edge); pass/fail_code/hit_idx stay stable while done=1.
REQ-024 In DONE, start=1 re-enters RUN with the same clears as REQ-013; start in RUN/DRAIN is ignored.

Reset
REQ-025 Reset SHALL asynchronously force IDLE, done=0, pass=0, fail_code=0, hit_idx=0, cycle_count=0, all internal counters 0 and the stored previous pc to 0, including mid-RUN or mid-DRAIN.
REQ-026 The first rising edge after reset release SHALL be evaluated normally (start sampled on it).

Structure
REQ-027 State enum and fail_code encodings SHALL live in shared package riscv_mon_pkg.
REQ-028 Watch matching SHALL be one sub-module, riscv_watch_match (NUM_WATCH channels -> hit, hit_idx, hit_pass), purely combinational; all sequential logic stays in riscv_run_monitor.

Verification
REQ-029 ch0 addr=0x36 rd=0xA pass=1, start at cycle 0, match at RUN cycle 12, DRAIN=2 -> done=1 three edges after the match edge, pass=1, fail_code=0, hit_idx=0, cycle_count=14.
REQ-030 ch0 and ch1 both match, cfg_pass=0 on ch1 only -> hit_idx=0, pass=1; swapping pass bits -> hit_idx=0, pass=0, fail_code=1.
REQ-031 No match, pc advancing by 4, MAX_CYCLES=20 -> done with fail_code=2, cycle_count=19.
REQ-032 pc held at 0x40 from RUN cycle 5, HANG_LIMIT=8 -> fail_code=3 at cycle 12; hang and match in the same cycle -> watch result wins.
REQ-033 cfg_need_we=1 with regWrite=0 during address/rd match -> no hit; regWrite=1 one cycle later -> hit.
REQ-034 reset asserted mid-DRAIN -> outputs 0 immediately (asynchronous, before the next edge); a new start reruns cleanly from cycle_count=0.
